// File: rtl/gsn_mac_pkg.sv
// Shared constants and elaboration helpers for the Gaussian-smoothing MAC.
package gsn_mac_pkg;

  localparam bit MODE_UNSIGNED = 1'b0;
  localparam bit MODE_SIGNED   = 1'b1;

  // Widest accumulator the saturation helper can describe.
  localparam int MAX_ACC_WIDTH = 63;

  // Clamp value for an accumulator of the given width, as a raw bit pattern
  // in the low 'width' bits. For signed mode the minimum is 100..0.
  function automatic logic [63:0] sat_limit(input int width, input bit mode,
                                            input bit want_max);
    logic [63:0] one;
    one = 64'd1;
    if (mode == MODE_SIGNED) begin
      return want_max ? ((one << (width - 1)) - one) : (one << (width - 1));
    end
    return want_max ? ((one << width) - one) : 64'd0;
  endfunction

  // Parameter legality: the accumulator must hold a full product and the pipe
  // needs at least an operand stage plus the accumulator stage.
  function automatic bit params_ok(input int a_width, input int b_width,
                                   input int acc_width, input int num_stage);
    return (a_width > 0) && (b_width > 0) &&
           (acc_width >= a_width + b_width) &&
           (acc_width <= MAX_ACC_WIDTH) &&
           (num_stage >= 2);
  endfunction

endpackage

// File: rtl/gsn_mac_mul_pipe.sv
// Operand register, multiplier and product delay line. Valid/first/last
// travel alongside the product; everything moves only on i_adv.
module gsn_mac_mul_pipe
  import gsn_mac_pkg::*;
#(
  parameter int A_WIDTH   = 11,
  parameter int B_WIDTH   = 11,
  parameter int NUM_STAGE = 4,
  parameter bit SIGNED    = MODE_SIGNED
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_adv,
  input  logic                       i_valid,
  input  logic [A_WIDTH-1:0]         i_a,
  input  logic [B_WIDTH-1:0]         i_b,
  input  logic                       i_first,
  input  logic                       i_last,
  output logic                       o_valid,
  output logic                       o_first,
  output logic                       o_last,
  output logic [A_WIDTH+B_WIDTH-1:0] o_product
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;
  logic               r_v1;
  logic               r_f1;
  logic               r_l1;
  logic [P_WIDTH-1:0] w_prod;

  // Stage-1 sidebands: cleared by reset so in-flight beats are discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1 <= 1'b0;
      r_f1 <= 1'b0;
      r_l1 <= 1'b0;
    end else if (i_adv) begin
      r_v1 <= i_valid;
      r_f1 <= i_first;
      r_l1 <= i_last;
    end
  end

  // Stage-1 operand capture.
  // NOTE: datapath registers carry no reset; the valid sideband qualifies
  // them, and leaving reset off lets synthesis pack them into the DSP block.
  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  // Full-precision product; operands are widened before the multiply so the
  // result width is explicit in both modes.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with every output given a
    // value on every path, which keeps synthesis from inferring a latch.
    w_prod = '0;
    if (SIGNED == MODE_SIGNED) begin
      w_prod = P_WIDTH'($signed(r_a)) * P_WIDTH'($signed(r_b));
    end else begin
      w_prod = P_WIDTH'(r_a) * P_WIDTH'(r_b);
    end
  end

  if (NUM_STAGE == 2) begin : g_no_delay
    assign o_valid   = r_v1;
    assign o_first   = r_f1;
    assign o_last    = r_l1;
    assign o_product = w_prod;
  end else begin : g_delay
    localparam int DEPTH = NUM_STAGE - 2;

    logic [P_WIDTH-1:0] r_p [DEPTH];
    logic [DEPTH-1:0]   r_v;
    logic [DEPTH-1:0]   r_f;
    logic [DEPTH-1:0]   r_l;

    // Sideband shift register for the product stages.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_v <= '0;
        r_f <= '0;
        r_l <= '0;
      end else if (i_adv) begin
        r_v[0] <= r_v1;
        r_f[0] <= r_f1;
        r_l[0] <= r_l1;
        for (int i = 1; i < DEPTH; i++) begin
          r_v[i] <= r_v[i-1];
          r_f[i] <= r_f[i-1];
          r_l[i] <= r_l[i-1];
        end
      end
    end

    // Product delay line.
    always_ff @(posedge clk) begin
      if (i_adv) begin
        r_p[0] <= w_prod;
        for (int i = 1; i < DEPTH; i++) begin
          r_p[i] <= r_p[i-1];
        end
      end
    end

    assign o_valid   = r_v[DEPTH-1];
    assign o_first   = r_f[DEPTH-1];
    assign o_last    = r_l[DEPTH-1];
    assign o_product = r_p[DEPTH-1];
  end

endmodule

// File: rtl/gsn_mac_pipe.sv
// Pipelined multiply-accumulate for the Gaussian smoothing datapath. Products
// of a frame (first/last delimited) are summed with saturation; one result
// per frame leaves on a valid/ready port. Backpressure stalls the whole pipe.
module gsn_mac_pipe
  import gsn_mac_pkg::*;
#(
  parameter int A_WIDTH   = 11,
  parameter int B_WIDTH   = 11,
  parameter int ACC_WIDTH = 26,
  parameter int NUM_STAGE = 4,
  parameter bit SIGNED    = MODE_SIGNED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_sat
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'(sat_limit(ACC_WIDTH, SIGNED, 1'b1));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN =
    ACC_WIDTH'(sat_limit(ACC_WIDTH, SIGNED, 1'b0));

  if (!params_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, NUM_STAGE)) begin : g_bad_params
    $error("gsn_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH and NUM_STAGE >= 2");
  end

  logic                 w_adv;
  logic                 w_pv;
  logic                 w_pf;
  logic                 w_pl;
  logic [P_WIDTH-1:0]   w_prod;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;
  logic                 w_start;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_sat_next;

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sat_sticky;
  logic                 r_frame_open;
  logic [ACC_WIDTH-1:0] r_dout;
  logic                 r_dout_sat;
  logic                 r_out_valid;

  // The pipe advances unless a held result is waiting on downstream.
  assign w_adv     = ce && !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign dout_sat  = r_dout_sat;

  gsn_mac_mul_pipe #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .NUM_STAGE (NUM_STAGE),
    .SIGNED    (SIGNED)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_adv     (w_adv),
    .i_valid   (in_valid),
    .i_a       (din0),
    .i_b       (din1),
    .i_first   (in_first),
    .i_last    (in_last),
    .o_valid   (w_pv),
    .o_first   (w_pf),
    .o_last    (w_pl),
    .o_product (w_prod)
  );

  // Next accumulator value: restart on a frame start, otherwise a saturating
  // add computed one bit wider than the accumulator to expose overflow.
  always_comb begin
    w_ext      = '0;
    w_sum      = '0;
    w_ovf      = 1'b0;
    w_acc_next = r_acc;
    w_sat_next = r_sat_sticky;
    if (SIGNED == MODE_SIGNED) begin
      w_ext = ACC_WIDTH'($signed(w_prod));
      w_sum = (ACC_WIDTH+1)'($signed(r_acc)) + (ACC_WIDTH+1)'($signed(w_ext));
      w_ovf = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];
    end else begin
      w_ext = ACC_WIDTH'(w_prod);
      w_sum = {1'b0, r_acc} + {1'b0, w_ext};
      w_ovf = w_sum[ACC_WIDTH];
    end
    w_start = w_pf || !r_frame_open;
    if (w_start) begin
      w_acc_next = w_ext;
      w_sat_next = 1'b0;
    end else if (w_ovf) begin
      // Signed: the extra top bit is the true sign, so it picks the rail.
      if (SIGNED == MODE_SIGNED) begin
        w_acc_next = w_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
      end else begin
        w_acc_next = SAT_MAX;
      end
      w_sat_next = 1'b1;
    end else begin
      w_acc_next = w_sum[ACC_WIDTH-1:0];
      w_sat_next = r_sat_sticky;
    end
  end

  // Accumulator stage: consumes one product beat per advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc        <= '0;
      r_sat_sticky <= 1'b0;
      r_frame_open <= 1'b0;
    end else if (w_adv && w_pv) begin
      r_acc        <= w_acc_next;
      r_sat_sticky <= w_sat_next;
      r_frame_open <= !w_pl;
    end
  end

  // Output register and handshake: a last beat loads a new result, which may
  // replace one being accepted on the same edge without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_dout_sat  <= 1'b0;
    end else if (ce) begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_adv && w_pv && w_pl) begin
        r_out_valid <= 1'b1;
        r_dout      <= w_acc_next;
        r_dout_sat  <= w_sat_next;
      end
    end
  end

endmodule

// File: tb/tb_gsn_mac_pipe.sv
// Scoreboard bench for gsn_mac_pipe: the stimulus side feeds a frame-level
// reference model and queues expected results; a monitor pops and compares
// each result the DUT presents, including its latency in advancing edges.
module tb_gsn_mac_pipe;

  localparam int AW   = 11;
  localparam int BW   = 11;
  localparam int ACCW = 26;
  localparam int NS   = 4;
  localparam longint SMAX = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (ACCW - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main (default-parameter) DUT.
  logic            reset, ce, in_valid, in_first, in_last, out_ready;
  logic [AW-1:0]   din0;
  logic [BW-1:0]   din1;
  logic            in_ready, out_valid, dout_sat;
  logic [ACCW-1:0] dout;

  // Unsigned 8x8 -> 16 variant.
  logic        u_ce, u_in_valid, u_first, u_last, u_out_ready;
  logic [7:0]  u_din0, u_din1;
  logic        u_in_ready, u_out_valid, u_dout_sat;
  logic [15:0] u_dout;

  // Two-stage variant.
  logic            n_ce, n_in_valid, n_first, n_last, n_out_ready;
  logic [AW-1:0]   n_din0;
  logic [BW-1:0]   n_din1;
  logic            n_in_ready, n_out_valid, n_dout_sat;
  logic [ACCW-1:0] n_dout;

  gsn_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_sat(dout_sat)
  );

  gsn_mac_pipe #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .NUM_STAGE(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .ce(u_ce), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .din0(u_din0), .din1(u_din1), .in_first(u_first), .in_last(u_last),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .dout(u_dout), .dout_sat(u_dout_sat)
  );

  gsn_mac_pipe #(.NUM_STAGE(2)) dut_n2 (
    .clk(clk), .reset(reset), .ce(n_ce), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .din0(n_din0), .din1(n_din1), .in_first(n_first), .in_last(n_last),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .dout(n_dout), .dout_sat(n_dout_sat)
  );

  typedef struct {
    logic [ACCW-1:0] dout;
    logic            sat;
    int              edge_no;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     fails  = 0;
  int     adv_cnt = 0;
  longint m_acc = 0;
  bit     m_sat = 1'b0;
  bit     m_open = 1'b0;
  int     stall_cnt = 0;
  bit     rand_mode = 1'b0;
  bit     ce_toggle = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      ce        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end else begin
      ce = ce_toggle ? ~ce : 1'b1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
    end
  endtask

  // Frame-level reference: restart on first or when no frame is open,
  // otherwise add and clamp to the signed accumulator range.
  task automatic model_accept(input int a, input int b, input bit f, input bit l);
    longint p, s;
    exp_t e;
    p = longint'(a) * longint'(b);
    if (f || !m_open) begin
      m_acc = p;
      m_sat = 1'b0;
    end else begin
      s = m_acc + p;
      if (s > SMAX) begin
        m_acc = SMAX;
        m_sat = 1'b1;
      end else if (s < SMIN) begin
        m_acc = SMIN;
        m_sat = 1'b1;
      end else begin
        m_acc = s;
      end
    end
    m_open = !l;
    if (l) begin
      e.dout    = ACCW'(m_acc);
      e.sat     = m_sat;
      e.edge_no = adv_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic send_beat(input int a, input int b, input bit f, input bit l);
    bit acc;
    din0     = AW'(a);
    din1     = BW'(b);
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        model_accept(a, b, f, l);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() > 0; t++) tick();
    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
  endtask

  function automatic int rand_op();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? -1024 : 1023;
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  // Monitor: handshake rule on every cycle, then result value, sticky flag,
  // latency on first sighting and stability while the result is held.
  task automatic monitor();
    bit   shown;
    bit   adv_tb;
    exp_t cur;
    shown = 1'b0;
    cur.dout = '0;
    cur.sat = 1'b0;
    cur.edge_no = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        shown = 1'b0;
        continue;
      end
      adv_tb = ce && !(out_valid && !out_ready);
      check("in_ready", in_ready, adv_tb);
      if (out_valid && !shown) begin
        if (sb.size() == 0) begin
          check("unexpected_result", out_valid, 0);
        end else begin
          cur = sb.pop_front();
          check("dout", $signed(dout), $signed(cur.dout));
          check("dout_sat", dout_sat, cur.sat);
          check("latency_adv_edges", adv_cnt, cur.edge_no + NS - 1);
        end
        shown = 1'b1;
      end else if (out_valid && shown) begin
        check("dout_stable", $signed(dout), $signed(cur.dout));
        check("dout_sat_stable", dout_sat, cur.sat);
      end
      if (out_valid && out_ready && ce) shown = 1'b0;
      if (adv_tb) adv_cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    in_first = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0;
    u_ce = 1'b1; u_out_ready = 1'b1; u_in_valid = 1'b0; u_first = 1'b0; u_last = 1'b0;
    u_din0 = '0; u_din1 = '0;
    n_ce = 1'b1; n_out_ready = 1'b1; n_in_valid = 1'b0; n_first = 1'b0; n_last = 1'b0;
    n_din0 = '0; n_din1 = '0;

    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state.
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_sat", dout_sat, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    tick();

    // Mixed-sign three-beat frame: 12 - 30 - 14 = -32.
    send_beat(3, 4, 1, 0);
    send_beat(-5, 6, 0, 0);
    send_beat(7, -2, 0, 1);
    drain();

    // Positive saturation, then a one-beat frame clears the sticky flag.
    for (int i = 0; i < 32; i++) send_beat(-1024, -1024, i == 0, i == 31);
    send_beat(2, 2, 1, 1);
    drain();

    // Negative saturation.
    for (int i = 0; i < 33; i++) send_beat(-1024, 1023, i == 0, i == 32);
    drain();

    // Back-to-back one-beat frames with a 5-cycle backpressure window.
    for (int i = 1; i <= 8; i++) begin
      send_beat(i, i, 1, 1);
      if (i == 4) stall_cnt = 5;
    end
    drain();

    // Clock enable toggling every cycle during a 4-beat frame.
    ce_toggle = 1'b1;
    send_beat(10, 11, 1, 0);
    send_beat(-12, 13, 0, 0);
    send_beat(14, 15, 0, 0);
    send_beat(-16, -17, 0, 1);
    drain();
    ce_toggle = 1'b0;
    tick();

    // Reset mid-frame: one finished result on the output, two beats in flight.
    send_beat(6, 7, 1, 1);
    send_beat(8, 9, 1, 0);
    send_beat(10, 10, 0, 0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dout", dout, 0);
    check("midrst_dout_sat", dout_sat, 0);
    check("midrst_in_ready", in_ready, ce);
    sb.delete();
    m_open = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_beat(5, 5, 1, 0);
    send_beat(1, 1, 0, 1);
    drain();

    // Randomised frames, including implicit starts, with random ce/out_ready.
    rand_mode = 1'b1;
    for (int i = 0; i < 120; i++) begin
      send_beat(rand_op(), rand_op(), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    rand_mode = 1'b0;
    send_beat(1, 1, 0, 1);
    drain();

    // Unsigned variant: 255*255 twice overflows 16 bits.
    u_din0 = 8'd255; u_din1 = 8'd255; u_first = 1'b1; u_last = 1'b0; u_in_valid = 1'b1;
    check("u_in_ready", u_in_ready, 1);
    tick();
    u_first = 1'b0; u_last = 1'b1;
    tick();
    u_in_valid = 1'b0;
    for (int t = 0; t < 20 && !u_out_valid; t++) tick();
    check("u_out_valid", u_out_valid, 1);
    check("u_dout", u_dout, 65535);
    check("u_dout_sat", u_dout_sat, 1);

    // Two-stage variant: result on the edge after acceptance.
    n_din0 = AW'(3); n_din1 = BW'(3); n_first = 1'b1; n_last = 1'b1; n_in_valid = 1'b1;
    check("n2_in_ready", n_in_ready, 1);
    tick();
    n_in_valid = 1'b0;
    check("n2_not_yet_valid", n_out_valid, 0);
    tick();
    check("n2_out_valid", n_out_valid, 1);
    check("n2_dout", n_dout, 9);
    check("n2_dout_sat", n_dout_sat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
